mod5_seq_monitor: RTL and testbench

MOD5_SEQ_MONITOR -- requirements
Module: mod5_seq_monitor

---
 rtl/mod5_seq_monitor.sv | 140 ++++++++++++++
 tb/tb_mod5_seq_monitor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mod5_seq_monitor.sv
// Sequence monitor for an upstream mod-MOD counter. Locks onto a correctly
// incrementing count, reports wraps while locked, and records the first
// sequencing error (skip, illegal value or stall) until cleared.
module mod5_seq_monitor #(
  parameter int unsigned MOD    = 5,
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned LOCK_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        count_in,
  input  logic              count_vld,
  input  logic              clr,
  output logic              locked,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned StreakW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [StreakW-1:0] LockTgt = StreakW'(LOCK_N);
  localparam logic [2:0]         Last    = 3'(MOD - 1);
  localparam logic [WRAP_W-1:0]  WrapMax = '1;

  localparam logic [1:0] CodeNone    = 2'b00;
  localparam logic [1:0] CodeSkip    = 2'b01;
  localparam logic [1:0] CodeIllegal = 2'b10;
  localparam logic [1:0] CodeStall   = 2'b11;

  typedef enum logic [1:0] {StUnlocked, StLocked, StError} state_e;

  state_e              state_q;
  logic [2:0]          prev_q;
  logic                seeded_q;
  logic [StreakW-1:0]  streak_q;
  logic                locked_q;
  logic                wrap_pulse_q;
  logic [WRAP_W-1:0]   wrap_cnt_q;
  logic                err_q;
  logic [1:0]          err_code_q;

  logic [2:0]          expected;
  logic                illegal;
  logic [StreakW-1:0]  streak_inc;

  // Next legal count after prev, and sample legality.
  always_comb begin
    expected   = (prev_q == Last) ? 3'd0 : prev_q + 3'd1;
    illegal    = (32'(count_in) >= MOD);
    streak_inc = streak_q + 1'b1;
  end

  // Monitor FSM; all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StUnlocked;
      prev_q       <= '0;
      seeded_q     <= 1'b0;
      streak_q     <= '0;
      locked_q     <= 1'b0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      err_q        <= 1'b0;
      err_code_q   <= CodeNone;
    end else begin
      wrap_pulse_q <= 1'b0;
      if (clr) begin
        state_q    <= StUnlocked;
        seeded_q   <= 1'b0;
        streak_q   <= '0;
        locked_q   <= 1'b0;
        wrap_cnt_q <= '0;
        err_q      <= 1'b0;
        err_code_q <= CodeNone;
      end else if (count_vld && (state_q != StError) && illegal) begin
        state_q    <= StError;
        locked_q   <= 1'b0;
        err_q      <= 1'b1;
        err_code_q <= CodeIllegal;
      end else if (count_vld) begin
        case (state_q)
          StUnlocked: begin
            prev_q <= count_in;
            if (!seeded_q) begin
              // First sample after reset/clr only establishes the reference.
              seeded_q <= 1'b1;
              streak_q <= '0;
            end else if (count_in == expected) begin
              if (streak_inc >= LockTgt) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
                streak_q <= '0;
              end else begin
                streak_q <= streak_inc;
              end
            end else begin
              streak_q <= '0;
            end
          end
          StLocked: begin
            if (count_in == prev_q) begin
              state_q    <= StError;
              locked_q   <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= CodeStall;
            end else if (count_in == expected) begin
              prev_q <= count_in;
              if ((prev_q == Last) && (count_in == 3'd0)) begin
                wrap_pulse_q <= 1'b1;
                if (wrap_cnt_q != WrapMax) begin
                  wrap_cnt_q <= wrap_cnt_q + 1'b1;
                end
              end
            end else begin
              state_q    <= StError;
              locked_q   <= 1'b0;
              err_q      <= 1'b1;
              err_code_q <= CodeSkip;
            end
          end
          StError: begin
            // Samples are ignored until clr.
          end
          default: begin
            state_q  <= StUnlocked;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked     = locked_q;
  assign wrap_pulse = wrap_pulse_q;
  assign wrap_cnt   = wrap_cnt_q;
  assign err        = err_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_mod5_seq_monitor.sv
// Directed bench for mod5_seq_monitor: expected outputs are queued as each
// sample is driven and compared one edge later. A second instance with a
// 2-bit wrap counter shares the stimulus to exercise saturation.
module tb_mod5_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] count_in = '0;
  logic       count_vld = 1'b0;
  logic       clr = 1'b0;

  logic       locked, wrap_pulse, err;
  logic [7:0] wrap_cnt;
  logic [1:0] err_code;
  logic       locked2, wrap_pulse2, err2;
  logic [1:0] wrap_cnt2;
  logic [1:0] err_code2;

  typedef struct packed {
    logic       lk;
    logic       wp;
    logic [7:0] wc;
    logic       er;
    logic [1:0] code;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  mod5_seq_monitor #(.MOD(5), .WRAP_W(8), .LOCK_N(2)) dut (
    .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld), .clr(clr),
    .locked(locked), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .err(err),
    .err_code(err_code)
  );

  mod5_seq_monitor #(.MOD(5), .WRAP_W(2), .LOCK_N(2)) dut2 (
    .clk(clk), .rst(rst), .count_in(count_in), .count_vld(count_vld), .clr(clr),
    .locked(locked2), .wrap_pulse(wrap_pulse2), .wrap_cnt(wrap_cnt2), .err(err2),
    .err_code(err_code2)
  );

  function automatic obs_t obs1();
    obs_t o;
    o.lk = locked; o.wp = wrap_pulse; o.wc = wrap_cnt; o.er = err; o.code = err_code;
    return o;
  endfunction

  function automatic obs_t obs2();
    obs_t o;
    o.lk = locked2; o.wp = wrap_pulse2; o.wc = {6'b0, wrap_cnt2}; o.er = err2;
    o.code = err_code2;
    return o;
  endfunction

  task automatic cmp(input string tag, input obs_t got, input obs_t want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got lk=%0b wp=%0b wc=%0d err=%0b code=%b, want lk=%0b wp=%0b wc=%0d err=%0b code=%b",
             tag, got.lk, got.wp, got.wc, got.er, got.code,
             want.lk, want.wp, want.wc, want.er, want.code);
    end
  endtask

  // Both instances must read all-zero outputs.
  task automatic check_zero(input string tag);
    cmp(tag, obs1(), '0);
    cmp({tag, "/w2"}, obs2(), '0);
  endtask

  // Drive one cycle of stimulus, queue the expectation, compare after the edge.
  task automatic step(input logic v, input logic [2:0] val, input logic c, input string tag,
                      input logic l, input logic wp, input int wc, input logic e,
                      input logic [1:0] code);
    obs_t  x;
    string t;
    @(negedge clk);
    count_vld = v; count_in = val; clr = c;
    x.lk = l; x.wp = wp; x.wc = 8'(wc); x.er = e; x.code = code;
    exp_q.push_back(x);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    cmp(t, obs1(), x);
    x.wc = (wc > 3) ? 8'd3 : 8'(wc);
    cmp({t, "/w2"}, obs2(), x);
  endtask

  initial begin
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Basic lock and wrap.
    step(1, 3'd0, 0, "seed0",   0, 0, 0, 0, 2'b00);
    step(1, 3'd1, 0, "s1",      0, 0, 0, 0, 2'b00);
    step(1, 3'd2, 0, "lock2",   1, 0, 0, 0, 2'b00);
    step(1, 3'd3, 0, "s3",      1, 0, 0, 0, 2'b00);
    step(1, 3'd4, 0, "s4",      1, 0, 0, 0, 2'b00);
    step(1, 3'd0, 0, "wrap1",   1, 1, 1, 0, 2'b00);
    step(1, 3'd1, 0, "postwrap", 1, 0, 1, 0, 2'b00);

    // Gaps are not errors and leave state alone.
    for (int i = 0; i < 3; i++) step(0, 3'd4, 0, "gap", 1, 0, 1, 0, 2'b00);
    step(1, 3'd2, 0, "g2",      1, 0, 1, 0, 2'b00);
    step(1, 3'd3, 0, "g3",      1, 0, 1, 0, 2'b00);
    step(1, 3'd4, 0, "g4",      1, 0, 1, 0, 2'b00);
    step(1, 3'd0, 0, "wrap2",   1, 1, 2, 0, 2'b00);
    step(1, 3'd1, 0, "w2_1",    1, 0, 2, 0, 2'b00);

    // Skip error, then ignored samples, then clr.
    step(1, 3'd2, 0, "k2",      1, 0, 2, 0, 2'b00);
    step(1, 3'd3, 0, "k3",      1, 0, 2, 0, 2'b00);
    step(1, 3'd0, 0, "skip",    0, 0, 2, 1, 2'b01);
    step(1, 3'd1, 0, "ign1",    0, 0, 2, 1, 2'b01);
    step(1, 3'd2, 0, "ign2",    0, 0, 2, 1, 2'b01);
    step(1, 3'd7, 0, "ign7",    0, 0, 2, 1, 2'b01);
    step(0, 3'd0, 1, "clr1",    0, 0, 0, 0, 2'b00);

    // Illegal value while locked; clr beats a simultaneous sample.
    step(1, 3'd2, 0, "r2",      0, 0, 0, 0, 2'b00);
    step(1, 3'd3, 0, "r3",      0, 0, 0, 0, 2'b00);
    step(1, 3'd4, 0, "rlock4",  1, 0, 0, 0, 2'b00);
    step(1, 3'd6, 0, "illegal", 0, 0, 0, 1, 2'b10);
    step(1, 3'd3, 1, "clrwins", 0, 0, 0, 0, 2'b00);
    step(1, 3'd0, 0, "reseed",  0, 0, 0, 0, 2'b00);
    step(1, 3'd1, 0, "rs1",     0, 0, 0, 0, 2'b00);
    step(1, 3'd2, 0, "rslock",  1, 0, 0, 0, 2'b00);

    // Stall error; first code is kept.
    step(1, 3'd2, 0, "stall",   0, 0, 0, 1, 2'b11);
    step(1, 3'd7, 0, "keep11",  0, 0, 0, 1, 2'b11);
    step(0, 3'd0, 1, "clr2",    0, 0, 0, 0, 2'b00);

    // A mismatch while unlocked restarts the streak.
    step(1, 3'd1, 0, "u_seed",  0, 0, 0, 0, 2'b00);
    step(1, 3'd2, 0, "u_ok",    0, 0, 0, 0, 2'b00);
    step(1, 3'd4, 0, "u_miss",  0, 0, 0, 0, 2'b00);
    step(1, 3'd0, 0, "u_ok2",   0, 0, 0, 0, 2'b00);
    step(1, 3'd1, 0, "u_lock",  1, 0, 0, 0, 2'b00);
    step(0, 3'd0, 1, "clr3",    0, 0, 0, 0, 2'b00);

    // Illegal value while unlocked.
    step(1, 3'd5, 0, "u_ill",   0, 0, 0, 1, 2'b10);
    step(0, 3'd0, 1, "clr4",    0, 0, 0, 0, 2'b00);

    // Five wraps: 8-bit counter reaches 5, 2-bit counter saturates at 3.
    step(1, 3'd3, 0, "w_seed",  0, 0, 0, 0, 2'b00);
    step(1, 3'd4, 0, "w_4",     0, 0, 0, 0, 2'b00);
    step(1, 3'd0, 0, "w_lock0", 1, 0, 0, 0, 2'b00);
    for (int k = 0; k < 5; k++) begin
      for (int v = 1; v <= 4; v++) step(1, 3'(v), 0, "w_run", 1, 0, k, 0, 2'b00);
      step(1, 3'd0, 0, "w_wrap", 1, 1, k + 1, 0, 2'b00);
    end

    // Asynchronous reset between 4 and 0 while locked.
    step(1, 3'd1, 0, "a1",      1, 0, 5, 0, 2'b00);
    step(1, 3'd2, 0, "a2",      1, 0, 5, 0, 2'b00);
    step(1, 3'd3, 0, "a3",      1, 0, 5, 0, 2'b00);
    step(1, 3'd4, 0, "a4",      1, 0, 5, 0, 2'b00);
    #2 rst = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    count_in = 3'd0; count_vld = 1'b1;
    @(posedge clk);
    #1 check_zero("no_wrap_in_rst");
    @(negedge clk);
    rst = 1'b1; count_vld = 1'b0;
    step(1, 3'd0, 0, "p_seed",  0, 0, 0, 0, 2'b00);
    step(1, 3'd1, 0, "p_1",     0, 0, 0, 0, 2'b00);
    step(1, 3'd2, 0, "p_lock",  1, 0, 0, 0, 2'b00);
    step(0, 3'd0, 0, "p_idle",  1, 0, 0, 0, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
